// File: rtl/pong_pkg.sv
// Shared definitions for the pong input-conditioning path: debounce FSM
// state encoding, default filter length and counter-width helper.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_WAIT_HI  = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_WAIT_LO  = 2'd3
  } state_e;

  // 20 ms of stable input at 50 MHz
  localparam int unsigned DB_CYCLES_DEFAULT = 1000000;

  // Bits needed to hold 0..n-1
  function automatic int unsigned clog2_u(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned v = n - 1; v != 0; v = v >> 1) begin
      w++;
    end
    return w;
  endfunction

  localparam int unsigned CNT_W_DEFAULT = clog2_u(DB_CYCLES_DEFAULT);

endpackage

// File: rtl/pong_btn_debounce_if.sv
// Button bundle between the pad ring and the debouncer: raw pad levels in,
// clean levels and press pulses out.
interface pong_btn_debounce_if #(
  parameter int unsigned N_BTN = 2
);

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_db;
  logic [N_BTN-1:0] btn_tick;

  modport master (output btn_raw, input btn_db, input btn_tick);
  modport slave  (input btn_raw, output btn_db, output btn_tick);

endinterface

// File: rtl/pong_btn_debounce_chan.sv
// One button channel: two-flop synchroniser, counter-qualified debounce FSM,
// registered level and one-cycle press pulse.
module debounce_chan
  import pong_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int unsigned CNT_W     = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_db,
  output logic btn_tick
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;
  logic             tick_q, tick_d;
  logic             s;

  assign s = sync_q[1];

  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RELEASED: begin
        if (s) begin
          state_d = ST_WAIT_HI;
          cnt_d   = '0;
        end
      end
      ST_WAIT_HI: begin
        if (!s) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (!s) begin
          state_d = ST_WAIT_LO;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LO: begin
        if (s) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_RELEASED;
        cnt_d   = '0;
      end
    endcase
    // Outputs registered from the next state so they change on the accepting edge
    db_d   = (state_d == ST_PRESSED) || (state_d == ST_WAIT_LO);
    tick_d = (state_q == ST_WAIT_HI) && (state_d == ST_PRESSED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= ST_RELEASED;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      tick_q  <= tick_d;
    end
  end

  assign btn_db   = db_q;
  assign btn_tick = tick_q;

endmodule

// File: rtl/pong_btn_debounce.sv
// Paddle button conditioning: N_BTN independent debounce channels feeding the
// game's btn input (btn_db) plus per-button press pulses (btn_tick).
module pong_btn_debounce
  import pong_pkg::*;
#(
  parameter int unsigned N_BTN     = 2,
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int unsigned CNT_W     = CNT_W_DEFAULT
) (
  input  logic              CLK_50MHZ,
  input  logic              RESET,
  pong_btn_debounce_if.slave btn_if
);

  logic [N_BTN-1:0] db_w;
  logic [N_BTN-1:0] tick_w;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    debounce_chan #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_chan (
      .clk      (CLK_50MHZ),
      .rst      (RESET),
      .btn_raw  (btn_if.btn_raw[i]),
      .btn_db   (db_w[i]),
      .btn_tick (tick_w[i])
    );
  end

  assign btn_if.btn_db   = db_w;
  assign btn_if.btn_tick = tick_w;

endmodule

// File: tb/tb_pong_btn_debounce.sv
// Directed bench for pong_btn_debounce with DB_CYCLES=4: clean press/release,
// bounces, simultaneous presses, async reset and a single-cycle glitch.
module tb_pong_btn_debounce;

  logic CLK_50MHZ;
  logic RESET;

  pong_btn_debounce_if #(.N_BTN(2)) bif ();

  pong_btn_debounce #(
    .N_BTN     (2),
    .DB_CYCLES (4),
    .CNT_W     (3)
  ) dut (
    .CLK_50MHZ (CLK_50MHZ),
    .RESET     (RESET),
    .btn_if    (bif.slave)
  );

  initial CLK_50MHZ = 1'b0;
  always #10 CLK_50MHZ = ~CLK_50MHZ;

  int unsigned n_checks;
  int unsigned n_pass;
  int unsigned tick_cnt0;
  int unsigned tick_cnt1;
  logic [1:0]  seen_db;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock edge, then observe 1 ns later
  task automatic step();
    @(posedge CLK_50MHZ);
    #1;
    if (bif.btn_tick[0] === 1'b1) tick_cnt0++;
    if (bif.btn_tick[1] === 1'b1) tick_cnt1++;
    seen_db = seen_db | bif.btn_db;
  endtask

  task automatic clear_mon();
    tick_cnt0 = 0;
    tick_cnt1 = 0;
    seen_db   = '0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    clear_mon();
    RESET       = 1'b1;
    bif.btn_raw = '0;

    repeat (3) step();
    check("rst_db", 32'(bif.btn_db), 32'h0);
    check("rst_tick", 32'(bif.btn_tick), 32'h0);
    RESET = 1'b0;
    repeat (4) step();
    check("idle_db", 32'(bif.btn_db), 32'h0);

    // Clean press on channel 0: rises 7 edges after the drive point
    clear_mon();
    bif.btn_raw = 2'b01;
    repeat (6) step();
    check("press_db_early", 32'(bif.btn_db), 32'h0);
    step();
    check("press_db", 32'(bif.btn_db), 32'h1);
    check("press_tick", 32'(bif.btn_tick), 32'h1);
    step();
    check("press_tick_width", 32'(bif.btn_tick), 32'h0);
    check("press_db_hold", 32'(bif.btn_db), 32'h1);
    repeat (4) step();
    check("press_tick_cnt", tick_cnt0, 32'd1);
    check("press_other_chan", 32'(seen_db[1]), 32'h0);

    // Clean release
    clear_mon();
    bif.btn_raw = 2'b00;
    repeat (6) step();
    check("rel_db_early", 32'(bif.btn_db), 32'h1);
    step();
    check("rel_db", 32'(bif.btn_db), 32'h0);
    repeat (3) step();
    check("rel_tick_cnt", tick_cnt0, 32'd0);

    // Press bounce: 3 high, 1 low, then held high
    clear_mon();
    bif.btn_raw = 2'b01;
    repeat (3) step();
    bif.btn_raw = 2'b00;
    step();
    bif.btn_raw = 2'b01;
    repeat (6) step();
    check("pb_db_early", 32'(bif.btn_db), 32'h0);
    check("pb_no_early_tick", tick_cnt0, 32'd0);
    step();
    check("pb_db", 32'(bif.btn_db), 32'h1);
    check("pb_tick", 32'(bif.btn_tick), 32'h1);
    repeat (3) step();
    check("pb_tick_cnt", tick_cnt0, 32'd1);

    // Release bounce: 2 low, 2 high, then held low
    clear_mon();
    bif.btn_raw = 2'b00;
    repeat (2) step();
    bif.btn_raw = 2'b01;
    repeat (2) step();
    bif.btn_raw = 2'b00;
    repeat (3) step();
    check("rb_db_mid", 32'(bif.btn_db), 32'h1);
    repeat (3) step();
    check("rb_db_early", 32'(bif.btn_db), 32'h1);
    step();
    check("rb_db", 32'(bif.btn_db), 32'h0);
    repeat (3) step();
    check("rb_tick_cnt", tick_cnt0, 32'd0);

    // Simultaneous press then release on both channels
    clear_mon();
    bif.btn_raw = 2'b11;
    repeat (6) step();
    check("sim_db_early", 32'(bif.btn_db), 32'h0);
    step();
    check("sim_db", 32'(bif.btn_db), 32'h3);
    check("sim_tick", 32'(bif.btn_tick), 32'h3);
    step();
    check("sim_tick_width", 32'(bif.btn_tick), 32'h0);
    bif.btn_raw = 2'b00;
    repeat (6) step();
    check("sim_rel_early", 32'(bif.btn_db), 32'h3);
    step();
    check("sim_rel", 32'(bif.btn_db), 32'h0);
    repeat (2) step();
    check("sim_tick_cnt0", tick_cnt0, 32'd1);
    check("sim_tick_cnt1", tick_cnt1, 32'd1);

    // Reset three cycles into WAIT_HI with the button held
    clear_mon();
    bif.btn_raw = 2'b01;
    repeat (5) step();
    RESET = 1'b1;
    #1;
    check("mid_rst_db", 32'(bif.btn_db), 32'h0);
    check("mid_rst_tick", 32'(bif.btn_tick), 32'h0);
    repeat (2) step();
    check("mid_rst_hold_db", 32'(bif.btn_db), 32'h0);
    RESET = 1'b0;
    repeat (6) step();
    check("post_rst_db_early", 32'(bif.btn_db), 32'h0);
    step();
    check("post_rst_db", 32'(bif.btn_db), 32'h1);
    check("post_rst_tick", 32'(bif.btn_tick), 32'h1);
    step();
    check("post_rst_tick_cnt", tick_cnt0, 32'd1);

    // Reset while pressed clears the level without a clock edge
    step();
    #4;
    RESET = 1'b1;
    #1;
    check("async_rst_db", 32'(bif.btn_db), 32'h0);
    step();
    RESET       = 1'b0;
    bif.btn_raw = 2'b00;
    repeat (4) step();
    check("async_rst_idle", 32'(bif.btn_db), 32'h0);

    // Single-cycle glitch on channel 1
    clear_mon();
    bif.btn_raw = 2'b10;
    step();
    bif.btn_raw = 2'b00;
    repeat (12) step();
    check("glitch_db", 32'(seen_db), 32'h0);
    check("glitch_tick1", tick_cnt1, 32'd0);
    check("glitch_tick0", tick_cnt0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pong_btn_debounce.md
# pong_btn_debounce

Input conditioning stage directly upstream of the pong graphics generator: takes the raw, asynchronous, bouncing paddle push-buttons and produces clean, synchronous button levels for the game's `btn[1:0]` input. It also produces a one-cycle press pulse per button for future menu and serve logic. Each button is synchronised, then filtered by a counter-qualified state machine. Everything runs on the 50 MHz system clock.

## Interface
- `N_BTN`, 2, number of independent button channels.
- `DB_CYCLES`, 1000000, cycles of stable input required to accept a level change (20 ms at 50 MHz); legal range is 2 or more.
- `CNT_W`, 20, counter width; must satisfy 2^CNT_W ≥ DB_CYCLES.

- `CLK_50MHZ`  in  1  system clock.
- `RESET`  in  1  asynchronous, active-high reset.
- `btn_raw`  in  N_BTN  raw pad inputs, active-high, asynchronous to the clock.
- `btn_db`  out  N_BTN  debounced level; feeds the game's `btn`.
- `btn_tick`  out  N_BTN  one-cycle pulse on each accepted press.

## Operation
- Per channel, a two-flop synchroniser is followed by one FSM and one CNT_W-bit counter. Channels are fully independent.
- FSM states: RELEASED, WAIT_HI, PRESSED, WAIT_LO. The synchroniser output is `s`.
- RELEASED:
  - If s=1, go to WAIT_HI and clear the counter.
  - Otherwise stay.
- WAIT_HI:
  - If s=0, return to RELEASED. A bounce discards progress.
  - Otherwise increment the counter.
  - When the counter equals DB_CYCLES-1 with s=1, go to PRESSED.
- PRESSED:
  - If s=0, go to WAIT_LO and clear the counter.
- WAIT_LO:
  - Mirror of WAIT_HI.
  - If s=1, return to PRESSED.
  - After DB_CYCLES consecutive s=0 cycles, go to RELEASED.
- `btn_db` is 1 in PRESSED and WAIT_LO, and 0 in RELEASED and WAIT_HI. It is registered, with no combinational path from the input.
- `btn_tick` is 1 only on the first cycle in PRESSED after a WAIT_HI→PRESSED transition.
  - A WAIT_LO→PRESSED return (release bounce) does not fire a tick.
  - Releases never produce a tick.
- The counter runs only in WAIT states. It never exceeds DB_CYCLES-1, so it cannot wrap.
- Reset (any time, including mid-count) forces:
  - synchronisers to 0
  - all FSMs to RELEASED
  - counters to 0
  - `btn_db`=0 and `btn_tick`=0
- A button held through reset deassertion is treated as a fresh press. It is accepted after the normal latency and generates a tick.

## Timing
- Raw rising edge sampled at clock edge k: `s`=1 after edge k+1, and the FSM enters WAIT_HI at edge k+2.
- `btn_db` rises and `btn_tick` pulses at edge k+2+DB_CYCLES. The tick lasts exactly one cycle.
- Release latency is identical: `btn_db` falls at edge k+2+DB_CYCLES after the raw falling edge.
- Any input pulse shorter than DB_CYCLES synchronised cycles produces no output change.
- Simultaneous presses on different channels resolve independently and may tick on the same cycle.
- Throughput: after one press is accepted, the next press cannot be accepted for at least 2·DB_CYCLES cycles (release plus re-press).

## Structure
- Shared package `pong_pkg`:
  - FSM state encoding (2-bit constants ST_RELEASED, ST_WAIT_HI, ST_PRESSED, ST_WAIT_LO)
  - default DB_CYCLES
  - a clog2-style width constant for CNT_W
- Sub-module `debounce_chan`: one synchroniser, FSM and counter with scalar I/O.
  - `pong_btn_debounce` generates N_BTN instances and concatenates their outputs.
- Top-level integration: replace the direct `btn` connection to the game with `btn_db`. `btn_tick` is left unconnected for now.

## Test plan
All scenarios use DB_CYCLES=4, CNT_W=3.
- Clean press: `btn_raw[0]` 0→1 sampled at edge 10 and held → `btn_db[0]`=1 from edge 16; `btn_tick[0]`=1 on edge 16 only; `btn_db[1]` stays 0.
- Press bounce: raw[0] high for 3 cycles, low for 1, then held high → no output until 4 stable cycles; `btn_db` rises 6 edges after the final rise; exactly one tick.
- Release bounce: from pressed, raw low for 2 cycles, then high for 2, then low and held → `btn_db` stays 1 through the bounce and falls 6 edges after the final fall; zero ticks.
- Simultaneous: both raw bits rise on the same edge → both `btn_db` bits rise and both ticks pulse on the identical edge.
- Reset mid-count: assert RESET 3 cycles into WAIT_HI with raw held high → outputs 0 immediately (asynchronously). After deassertion, `btn_db` rises 6 edges later with one tick.
- Single-cycle glitch: a 1-cycle raw pulse → `btn_db` and `btn_tick` never assert.
